// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the byte-stream instruction loader.
package inst_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_t;

  localparam int HDR_BYTES  = 4;
  localparam int WORD_BYTES = 4;
  localparam int ADDR_INC   = 4;

endpackage

// File: rtl/inst_loader_if.sv
// Byte-stream input and instruction-RAM write port of the loader.
interface inst_loader_if #(
  parameter int W = 32
) ();
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         is_write;
  logic [W-1:0] im_addr;
  logic [W-1:0] im_inst;

  // master: byte source / RAM side; slave: the loader itself
  modport master (output in_valid, in_data, input in_ready, is_write, im_addr, im_inst);
  modport slave  (input in_valid, in_data, output in_ready, is_write, im_addr, im_inst);
endinterface

// File: rtl/inst_loader_byte_assembler.sv
// Little-endian byte-to-word assembler shared by the header and data phases.
// word/word_valid are combinational so the 4th byte is usable in its own cycle.
module byte_assembler
  import inst_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    byte_valid,
  input  logic [7:0]              byte_data,
  output logic [8*WORD_BYTES-1:0] word,
  output logic                    word_valid
);
  localparam int CNT_W = $clog2(WORD_BYTES);
  localparam int SH_W  = 8 * (WORD_BYTES - 1);

  logic [CNT_W-1:0] byte_cnt;
  logic [SH_W-1:0]  shift_q;

  assign word_valid = byte_valid && (byte_cnt == CNT_W'(WORD_BYTES - 1));
  assign word       = {byte_data, shift_q};

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear)      byte_cnt <= '0;
    else if (word_valid)   byte_cnt <= '0;
    else if (byte_valid)   byte_cnt <= byte_cnt + CNT_W'(1);
  end

  // NOTE: pure data storage, no reset needed: it is only observed after a full word is shifted in.
  always_ff @(posedge clk) begin
    if (byte_valid) shift_q <= {byte_data, shift_q[SH_W-1:8]};
  end

endmodule

// File: rtl/inst_loader.sv
// Framed byte-stream program loader: length header, then words written to instruction RAM.
// Holds the core in reset until a frame has been loaded cleanly.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int          W              = 32,
  parameter int          DEPTH_WORDS    = 2048,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  inst_loader_if.slave                       bus,
  output logic                               cpu_hold,
  output logic                               load_done,
  output logic                               load_err,
  output logic [$clog2(DEPTH_WORDS+1)-1:0]   words_loaded
);
  localparam int CW = $clog2(DEPTH_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_t               state, state_nxt;
  logic                 busy, accept, start_go, timed_out, last_word;
  logic [8*WORD_BYTES-1:0] word;
  logic                 word_valid;
  logic [CW-1:0]        idx_q, len_q, words_q;
  logic [TW-1:0]        tmo_q;
  logic [W-1:0]         im_addr_q, im_inst_q;

  assign busy      = (state == S_HDR) || (state == S_DATA);
  assign accept    = busy && bus.in_valid;
  assign start_go  = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));
  assign timed_out = busy && !accept && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign last_word = ((idx_q + CW'(1)) == len_q);

  byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_go),
    .byte_valid (accept),
    .byte_data  (bus.in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_HDR;
      S_HDR: begin
        if (word_valid) begin
          if (word == '0)                     state_nxt = S_DONE;
          else if (word > 32'(DEPTH_WORDS))   state_nxt = S_ERR;
          else                                state_nxt = S_DATA;
        end else if (timed_out) begin
          state_nxt = S_ERR;
        end
      end
      S_DATA: begin
        if (word_valid)     state_nxt = S_WRITE;
        else if (timed_out) state_nxt = S_ERR;
      end
      S_WRITE: state_nxt = last_word ? S_DONE : S_DATA;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = 1'b0;
    bus.is_write = 1'b0;
    cpu_hold     = 1'b1;
    load_done    = 1'b0;
    load_err     = 1'b0;
    case (state)
      S_HDR, S_DATA: bus.in_ready = 1'b1;
      S_WRITE:       bus.is_write = 1'b1;
      S_DONE: begin
        cpu_hold  = 1'b0;
        load_done = 1'b1;
      end
      S_ERR:         load_err = 1'b1;
      default: ;
    endcase
  end

  // Idle counter only runs while a frame is collecting bytes; WRITE does not count as idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q     <= '0;
      len_q     <= '0;
      words_q   <= '0;
      tmo_q     <= '0;
      im_addr_q <= '0;
      im_inst_q <= '0;
    end else begin
      if (start_go) begin
        idx_q   <= '0;
        words_q <= '0;
        tmo_q   <= '0;
      end
      if (busy) tmo_q <= accept ? '0 : tmo_q + TW'(1);
      if (state == S_HDR && word_valid) len_q <= word[CW-1:0];
      if (state == S_DATA && word_valid) begin
        im_addr_q <= W'(BASE_ADDR) + W'(idx_q) * W'(ADDR_INC);
        im_inst_q <= W'(word);
      end
      if (state == S_WRITE) begin
        idx_q   <= idx_q + CW'(1);
        words_q <= words_q + CW'(1);
      end
    end
  end

  assign bus.im_addr   = im_addr_q;
  assign bus.im_inst   = im_inst_q;
  assign words_loaded  = words_q;

endmodule

// File: tb/tb_inst_loader.sv
// Self-checking bench: two loaders (base 0x0 and 0x100) fed the same byte stream.
module tb_inst_loader;
  localparam int          W     = 32;
  localparam int          DEPTH = 2048;
  localparam int          TMO   = 16;
  localparam logic [31:0] BASE0 = 32'h0;
  localparam logic [31:0] BASE1 = 32'h100;

  typedef logic [7:0] frame_t [12];
  typedef struct {
    string  name;
    int     n;
    frame_t b;
    logic   wr_last;
    logic   exp_done;
    logic   exp_err;
    int     exp_words;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic [7:0]  data = 8'h00;
  logic        hold0, hold1, done0, done1, err0, err1;
  logic [11:0] wl0, wl1;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [63:0] wq0[$];
  logic [63:0] wq1[$];
  vec_t        vecs[$];

  always #5 clk = ~clk;

  inst_loader_if #(.W(W)) if0 ();
  inst_loader_if #(.W(W)) if1 ();
  assign if0.in_valid = valid;
  assign if0.in_data  = data;
  assign if1.in_valid = valid;
  assign if1.in_data  = data;

  inst_loader #(.W(W), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE0), .TIMEOUT_CYCLES(TMO)) dut0 (
    .clk(clk), .rst(rst), .start(start), .bus(if0.slave),
    .cpu_hold(hold0), .load_done(done0), .load_err(err0), .words_loaded(wl0));
  inst_loader #(.W(W), .DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE1), .TIMEOUT_CYCLES(TMO)) dut1 (
    .clk(clk), .rst(rst), .start(start), .bus(if1.slave),
    .cpu_hold(hold1), .load_done(done1), .load_err(err1), .words_loaded(wl1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Every write strobe is recorded; the stream must be stalled while writing.
  always @(negedge clk) begin
    if (if0.is_write) begin
      wq0.push_back({if0.im_addr, if0.im_inst});
      check("wr_ready0", 32'(if0.in_ready), 0);
    end
    if (if1.is_write) begin
      wq1.push_back({if1.im_addr, if1.im_inst});
      check("wr_ready1", 32'(if1.in_ready), 0);
    end
  end

  // Reference: RAM image implied by a (possibly truncated) byte stream.
  function automatic void ref_model(input logic [7:0] bs[$], input logic [31:0] base,
                                    output logic [63:0] wr[$]);
    logic [31:0] len;
    logic [31:0] addr;
    wr = {};
    if (bs.size() < 4) return;
    len = {bs[3], bs[2], bs[1], bs[0]};
    if (len > 32'(DEPTH)) return;
    for (int k = 0; k < int'(len); k++) begin
      if (4 * k + 7 >= bs.size()) break;
      addr = base + 32'(4 * k);
      wr.push_back({addr, bs[4*k+7], bs[4*k+6], bs[4*k+5], bs[4*k+4]});
    end
  endfunction

  task automatic compare_writes(input string name, input logic [7:0] bs[$]);
    logic [63:0] e0[$];
    logic [63:0] e1[$];
    ref_model(bs, BASE0, e0);
    ref_model(bs, BASE1, e1);
    check({name, "/nwr0"}, 32'(wq0.size()), 32'(e0.size()));
    check({name, "/nwr1"}, 32'(wq1.size()), 32'(e1.size()));
    for (int k = 0; k < e0.size() && k < wq0.size(); k++) begin
      check({name, "/addr0"}, wq0[k][63:32], e0[k][63:32]);
      check({name, "/inst0"}, wq0[k][31:0],  e0[k][31:0]);
    end
    for (int k = 0; k < e1.size() && k < wq1.size(); k++) begin
      check({name, "/addr1"}, wq1[k][63:32], e1[k][63:32]);
      check({name, "/inst1"}, wq1[k][31:0],  e1[k][31:0]);
    end
    wq0.delete();
    wq1.delete();
  endtask

  task automatic check_status(input string tag, input logic d, input logic e, input int w);
    check({tag, "/done0"},  32'(done0), 32'(d));
    check({tag, "/done1"},  32'(done1), 32'(d));
    check({tag, "/err0"},   32'(err0),  32'(e));
    check({tag, "/err1"},   32'(err1),  32'(e));
    check({tag, "/hold0"},  32'(hold0), 32'(!d));
    check({tag, "/hold1"},  32'(hold1), 32'(!d));
    check({tag, "/words0"}, 32'(wl0),   32'(w));
    check({tag, "/words1"}, 32'(wl1),   32'(w));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "/ready"}, 32'(if0.in_ready), 0);
    check({tag, "/wr"},    32'(if0.is_write), 0);
    check({tag, "/addr0"}, if0.im_addr, 0);
    check({tag, "/addr1"}, if1.im_addr, 0);
    check({tag, "/inst0"}, if0.im_inst, 0);
    check({tag, "/inst1"}, if1.im_inst, 0);
    check_status(tag, 1'b0, 1'b0, 0);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int   guard;
    guard = 0;
    valid = 1'b1;
    data  = b;
    do begin
      rdy = if0.in_ready;
      @(posedge clk);
      @(negedge clk);
      guard++;
    end while (!rdy && guard < 64);
    check("byte_accept", 32'(rdy), 1);
    valid = 1'b0;
  endtask

  task automatic start_frame();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start/hold0", 32'(hold0), 1);
    check("start/done0", 32'(done0), 0);
    check("start/err0",  32'(err0),  0);
    check("start/ready", 32'(if0.in_ready), 1);
  endtask

  task automatic add_vec(input string nm, input int n, input frame_t b,
                         input logic wl, input logic d, input logic e, input int w);
    vec_t v;
    v.name = nm; v.n = n; v.b = b;
    v.wr_last = wl; v.exp_done = d; v.exp_err = e; v.exp_words = w;
    vecs.push_back(v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] bs[$];
    int         len;
    int         g;

    add_vec("two_words", 12, '{8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                               8'h93, 8'h00, 8'h10, 8'h00}, 1'b1, 1'b1, 1'b0, 2);
    add_vec("zero_len", 4, '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b1, 1'b0, 0);
    add_vec("too_long", 4, '{8'h01, 8'h08, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                             8'h00, 8'h00, 8'h00, 8'h00}, 1'b0, 1'b0, 1'b1, 0);
    add_vec("one_word", 8, '{8'h01, 8'h00, 8'h00, 8'h00, 8'hef, 8'hbe, 8'had, 8'hde,
                             8'h00, 8'h00, 8'h00, 8'h00}, 1'b1, 1'b1, 1'b0, 1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Table-driven frames, each started from IDLE/DONE/ERR.
    foreach (vecs[i]) begin
      bs = {};
      for (int j = 0; j < vecs[i].n; j++) bs.push_back(vecs[i].b[j]);
      start_frame();
      foreach (bs[j]) send_byte(bs[j]);
      check({vecs[i].name, "/wr_lat"}, 32'(if0.is_write), 32'(vecs[i].wr_last));
      check({vecs[i].name, "/early_done"}, 32'(done0), 32'(vecs[i].exp_done && !vecs[i].wr_last));
      check({vecs[i].name, "/early_err"},  32'(err0),  32'(vecs[i].exp_err));
      @(negedge clk);
      check({vecs[i].name, "/wr_end"}, 32'(if0.is_write), 0);
      check_status(vecs[i].name, vecs[i].exp_done, vecs[i].exp_err, vecs[i].exp_words);
      compare_writes(vecs[i].name, bs);
    end

    // Header equal to the depth limit is accepted.
    start_frame();
    bs = '{8'h00, 8'h08, 8'h00, 8'h00};
    foreach (bs[j]) send_byte(bs[j]);
    check("max_len/err",   32'(err0), 0);
    check("max_len/ready", 32'(if0.in_ready), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compare_writes("max_len", bs);

    // Idle timeout after a partial word, then a clean reload.
    start_frame();
    bs = '{8'h01, 8'h00, 8'h00, 8'h00, 8'haa, 8'hbb};
    foreach (bs[j]) send_byte(bs[j]);
    repeat (TMO - 1) @(negedge clk);
    check("tmo/not_yet", 32'(err0), 0);
    check("tmo/ready",   32'(if0.in_ready), 1);
    @(negedge clk);
    check_status("tmo", 1'b0, 1'b1, 0);
    check("tmo/ready_err", 32'(if0.in_ready), 0);
    compare_writes("tmo", bs);
    start_frame();
    bs = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
    foreach (bs[j]) send_byte(bs[j]);
    @(negedge clk);
    check_status("tmo_reload", 1'b1, 1'b0, 1);
    compare_writes("tmo_reload", bs);

    // Reset in the middle of the second word of a 3-word frame.
    start_frame();
    bs = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
    foreach (bs[j]) send_byte(bs[j]);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    valid = 1'b1;
    data = 8'h5a;
    repeat (4) @(negedge clk);
    check("rst_mid/idle_ready", 32'(if0.in_ready), 0);
    valid = 1'b0;
    compare_writes("rst_mid", bs);

    // Random frames with random stream gaps and stray start pulses.
    for (int f = 0; f < 6; f++) begin
      len = (f == 0) ? 3 : int'($urandom_range(1, 5));
      bs = {};
      bs.push_back(8'(len));
      bs.push_back(8'h00);
      bs.push_back(8'h00);
      bs.push_back(8'h00);
      for (int j = 0; j < 4 * len; j++) bs.push_back(8'($urandom));
      start_frame();
      for (int j = 0; j < bs.size(); j++) begin
        send_byte(bs[j]);
        if (j != bs.size() - 1) begin
          g = int'($urandom_range(0, 12));
          for (int c = 0; c < g; c++) begin
            start = (c == 0) && ($urandom_range(0, 3) == 0);
            @(negedge clk);
          end
          start = 1'b0;
        end
      end
      @(negedge clk);
      check_status("rand", 1'b1, 1'b0, len);
      compare_writes("rand", bs);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
